fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Generates the sequential PC and issues requests to instruction memory over a req/gnt/rvalid handshake, with at most one request outstanding.
- Buffers returned words in a 2-entry queue so that a decode stall (keep) loses nothing.
- Drives the IF/ID pipeline register (PC_pype0, PCp4_pype0, Instraction_pype); injects NOP bubbles on empty queue or on redirect from branch resolution.

---
 rtl/fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: sequential PC generation, single-outstanding imem
// handshake, small fetch queue and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype,
  output logic        fetch_valid
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  // state   | meaning
  // S_REQ   | request may be issued at fetch_pc_q
  // S_WAIT  | one request granted, its data will be queued
  // S_DISCARD | one request granted, its data will be dropped
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pc_mem_q   [QDEPTH];
  logic [31:0]     word_mem_q [QDEPTH];

  logic [31:0]     if_pc_q, if_pc_d;
  logic [31:0]     if_pcp4_q, if_pcp4_d;
  logic [31:0]     if_insn_q, if_insn_d;
  logic            if_valid_q, if_valid_d;

  logic [CW-1:0]   occ;
  logic            gnt_acc;
  logic            push;
  logic            pop;

  assign occ       = count_q + CW'(outstanding_q);
  assign imem_req  = !rst && (state_q == S_REQ) && (occ < CW'(QDEPTH));
  assign imem_addr = fetch_pc_q;
  assign gnt_acc   = imem_req && imem_gnt;
  assign push      = (state_q == S_WAIT) && imem_rvalid && !redirect;
  assign pop       = !redirect && !keep && (count_q != '0);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;

    case (state_q)
      S_REQ: begin
        if (gnt_acc) begin
          outstanding_d = 1'b1;
          fetch_pc_d    = fetch_pc_q + 32'd4;
          req_pc_d      = fetch_pc_q;
          state_d       = redirect ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          outstanding_d = 1'b0;
          state_d       = S_REQ;
        end else if (redirect) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) begin
          outstanding_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // The redirect target overrides the post-grant increment.
    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    if_pc_d    = if_pc_q;
    if_pcp4_d  = if_pcp4_q;
    if_insn_d  = if_insn_q;
    if_valid_d = if_valid_q;
    if (redirect || (!keep && count_q == '0)) begin
      if_pc_d    = 32'd0;
      if_pcp4_d  = 32'd0;
      if_insn_d  = NOP_INSN;
      if_valid_d = 1'b0;
    end else if (pop) begin
      if_pc_d    = pc_mem_q[rd_ptr_q];
      if_pcp4_d  = pc_mem_q[rd_ptr_q] + 32'd4;
      if_insn_d  = word_mem_q[rd_ptr_q];
      if_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= 32'd0;
      outstanding_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      if_pc_q       <= 32'd0;
      if_pcp4_q     <= 32'd0;
      if_insn_q     <= NOP_INSN;
      if_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      if_pc_q       <= if_pc_d;
      if_pcp4_q     <= if_pcp4_d;
      if_insn_q     <= if_insn_d;
      if_valid_q    <= if_valid_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
      word_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign PC_pype0         = if_pc_q;
  assign PCp4_pype0       = if_pcp4_q;
  assign Instraction_pype = if_insn_q;
  assign fetch_valid      = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst, keep, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_pype0, PCp4_pype0, Instraction_pype;
  logic        fetch_valid;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSN(NOP), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .keep(keep), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_pype0(PC_pype0), .PCp4_pype0(PCp4_pype0),
    .Instraction_pype(Instraction_pype), .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers each grant after mem_delay cycles with addr|0x100.
  bit          mem_pend = 0;
  int          mem_cnt  = 0;
  int          mem_delay = 1;
  logic [31:0] mem_addr = 0;

  // Reference model: fetch address, a queue of fetched {pc, word},
  // one pending request that may be marked as abandoned.
  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_fpc = 0;
  bit          m_pend = 0, m_disc = 0;
  logic [31:0] m_pend_pc = 0;
  logic [31:0] m_pc = 0, m_pc4 = 0, m_insn = NOP;
  bit          m_valid = 0;

  bit          last_req;
  logic [31:0] last_addr;

  task automatic m_bubble();
    m_pc = 0; m_pc4 = 0; m_insn = NOP; m_valid = 0;
  endtask

  task automatic model_step(input bit r, input bit k, input bit rd, input logic [31:0] rpc,
                            input bit req, input bit g, input bit rv_in, input logic [31:0] rdata);
    bit   rv, gnt_eff, do_push;
    ent_t e;
    if (r) begin
      m_fpc = 0; m_q.delete(); m_pend = 0; m_disc = 0; m_bubble();
      return;
    end
    gnt_eff = req && g;
    rv      = m_pend && rv_in;
    do_push = rv && !m_disc && !rd;
    if (rd) begin
      m_bubble(); m_q.delete();
    end else if (!k) begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_pc = e.pc; m_pc4 = e.pc + 32'd4; m_insn = e.w; m_valid = 1;
      end else m_bubble();
    end
    if (do_push) begin
      e.pc = m_pend_pc; e.w = rdata;
      m_q.push_back(e);
    end
    if (rv) begin m_pend = 0; m_disc = 0; end
    if (gnt_eff) begin
      m_pend = 1; m_disc = rd; m_pend_pc = m_fpc; m_fpc = m_fpc + 32'd4;
    end else if (rd && m_pend) m_disc = 1;
    if (rd) m_fpc = {rpc[31:2], 2'b00};
  endtask

  task automatic cycle(input bit k, input bit rd, input logic [31:0] rpc, input bit g, input bit r);
    bit          exp_req, granted, rv_in;
    logic [31:0] gaddr, rdata_in;
    @(negedge clk);
    rst = r; keep = k; redirect = rd; redirect_pc = rpc; imem_gnt = g;
    imem_rvalid = mem_pend && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? (mem_addr | 32'h100) : 32'hDEAD_BEEF;
    #1;
    exp_req = !r && !m_pend && ((m_q.size() + int'(m_pend)) < QD);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_fpc);
    last_req = imem_req; last_addr = imem_addr;
    granted = imem_req && imem_gnt; gaddr = imem_addr;
    rv_in = imem_rvalid; rdata_in = imem_rdata;
    @(posedge clk);
    model_step(r, k, rd, rpc, exp_req, g, rv_in, rdata_in);
    if (rv_in) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (granted) begin
      mem_pend = 1; mem_addr = gaddr; mem_cnt = mem_delay - 1;
    end
    #1;
    chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_valid});
    chk("PC_pype0", PC_pype0, m_pc);
    chk("PCp4_pype0", PCp4_pype0, m_pc4);
    chk("Instraction_pype", Instraction_pype, m_insn);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    mem_pend = 0;
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_insn", Instraction_pype, NOP);
    chk("rst_pc", PC_pype0, 32'd0);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] pc, input logic [31:0] insn);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(0, 0, 0, 1, 0);
      got = fetch_valid;
    end
    chk({name, "_arrive"}, {31'b0, got}, 32'd1);
    chk({name, "_pc"}, PC_pype0, pc);
    chk({name, "_insn"}, Instraction_pype, insn);
  endtask

  typedef struct {
    bit          keep;
    bit          gnt;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_insn;
  } vec_t;
  vec_t tbl[18];

  task automatic set_row(input int i, input bit k, input bit v, input logic [31:0] pc, input logic [31:0] insn);
    tbl[i] = '{keep: k, gnt: 1'b1, exp_valid: v, exp_pc: pc, exp_insn: insn};
  endtask

  initial begin
    rst = 1; keep = 0; redirect = 0; redirect_pc = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;

    // Streaming fetch, then an 8-cycle decode stall and release.
    set_row(0, 0, 0, 0, NOP);
    set_row(1, 0, 0, 0, NOP);
    set_row(2, 0, 1, 32'h0, 32'h100);
    set_row(3, 0, 0, 0, NOP);
    set_row(4, 0, 1, 32'h4, 32'h104);
    set_row(5, 0, 0, 0, NOP);
    set_row(6, 0, 1, 32'h8, 32'h108);
    for (int i = 7; i <= 14; i++) set_row(i, 1, 1, 32'h8, 32'h108);
    set_row(15, 0, 1, 32'hC, 32'h10C);
    set_row(16, 0, 1, 32'h10, 32'h110);
    set_row(17, 0, 0, 0, NOP);

    do_reset();
    mem_delay = 1;
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].keep, 0, 0, tbl[i].gnt, 0);
      if (i == 0) chk("first_addr", last_addr, 32'h0);
      if (i == 14) chk("req_when_full", {31'b0, last_req}, 32'd0);
      chk("tbl_valid", {31'b0, fetch_valid}, {31'b0, tbl[i].exp_valid});
      chk("tbl_pc", PC_pype0, tbl[i].exp_pc);
      chk("tbl_pcp4", PCp4_pype0, tbl[i].exp_valid ? tbl[i].exp_pc + 32'd4 : 32'd0);
      chk("tbl_insn", Instraction_pype, tbl[i].exp_insn);
    end

    // Redirect while waiting; the stale response arrives afterwards.
    do_reset();
    mem_delay = 2;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 32'h200, 1, 0);
    chk("redir_bubble_insn", Instraction_pype, NOP);
    cycle(0, 0, 0, 1, 0);
    chk("stale_valid", {31'b0, fetch_valid}, 32'd0);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h200);
    mem_delay = 1;
    wait_valid("redir_first", 32'h200, 32'h300);

    // Redirect together with keep while the queue is full.
    begin
      bit full = 0;
      for (int i = 0; i < 20 && !full; i++) begin
        cycle(1, 0, 0, 1, 0);
        full = !imem_req;
      end
      chk("queue_full_reached", {31'b0, full}, 32'd1);
    end
    cycle(1, 1, 32'h403, 1, 0);
    chk("rk_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rk_insn", Instraction_pype, NOP);
    chk("rk_pc", PC_pype0, 32'd0);
    chk("rk_req", {31'b0, imem_req}, 32'd1);
    chk("rk_addr", imem_addr, 32'h400);
    wait_valid("rk_first", 32'h400, 32'h500);

    // Grant withheld for five cycles.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("nogt_req", {31'b0, last_req}, 32'd1);
      chk("nogt_addr", last_addr, 32'h0);
      chk("nogt_valid", {31'b0, fetch_valid}, 32'd0);
    end
    wait_valid("nogt_first", 32'h0, 32'h100);

    // Reset while a response is in flight; it lands after reset.
    do_reset();
    cycle(0, 1, 32'h80, 0, 0);
    mem_delay = 2;
    cycle(0, 0, 0, 1, 0);
    chk("rw_grant_addr", last_addr, 32'h80);
    cycle(0, 0, 0, 0, 1);
    chk("rw_req_in_reset", {31'b0, last_req}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("rw_late_rvalid", {31'b0, imem_rvalid}, 32'd1);
    chk("rw_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rw_insn", Instraction_pype, NOP);
    chk("rw_addr", imem_addr, 32'h0);
    mem_delay = 1;
    wait_valid("rw_first", 32'h0, 32'h100);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          k, rd, g;
      logic [31:0] rpc;
      k   = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 99) < 4);
      g   = ($urandom_range(0, 9) < 7);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      mem_delay = $urandom_range(1, 3);
      cycle(k, rd, rpc, g, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
